// File: rtl/except_fetch_unit_if.sv
// except_fetch_unit_if
//   Bundles the fetch-side request, breakpoint programming, trap handshake
//   and exception status of the fetch exception unit.
//   master: the fetch/trap side that drives requests and reads status.
//   slave : the exception unit itself.
//   Signals:
//     PC, fetchValid, iAlign, pageFault         fetch request and MMU status
//     bpWrEn, bpWrIdx, bpWrAddr, bpWrArm        breakpoint entry write port
//     exceptAck, flush                          trap consume / pipeline flush
//     exceptValid, exceptSignal, exceptCause,
//     exceptPC, fetchStall, exceptCount         held exception status
interface except_fetch_unit_if #(
  parameter int N      = 64,
  parameter int NUM_BP = 4,
  parameter int CNT_W  = 16
);
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  logic [N-1:0]     PC;
  logic             fetchValid;
  logic             iAlign;
  logic             pageFault;
  logic             bpWrEn;
  logic [IDX_W-1:0] bpWrIdx;
  logic [N-1:0]     bpWrAddr;
  logic             bpWrArm;
  logic             exceptAck;
  logic             flush;
  logic             exceptValid;
  logic [3:0]       exceptSignal;
  logic [3:0]       exceptCause;
  logic [N-1:0]     exceptPC;
  logic             fetchStall;
  logic [CNT_W-1:0] exceptCount;

  modport master (
    output PC, fetchValid, iAlign, pageFault,
    output bpWrEn, bpWrIdx, bpWrAddr, bpWrArm,
    output exceptAck, flush,
    input  exceptValid, exceptSignal, exceptCause, exceptPC, fetchStall, exceptCount
  );

  modport slave (
    input  PC, fetchValid, iAlign, pageFault,
    input  bpWrEn, bpWrIdx, bpWrAddr, bpWrArm,
    input  exceptAck, flush,
    output exceptValid, exceptSignal, exceptCause, exceptPC, fetchStall, exceptCount
  );
endinterface

// File: rtl/except_fetch_unit.sv
// except_fetch_unit
//   Fetch-stage exception unit. Each valid fetch PC is checked for a
//   breakpoint hit, MMU page fault, out-of-range access and misalignment.
//   The highest-priority exception is captured into a holding register and
//   fetch is stalled until the trap logic acknowledges it or a flush drops it.
//   Ports:
//     clk    clock
//     reset  asynchronous, active-low reset
//     bus    except_fetch_unit_if.slave (fetch request, breakpoint writes,
//            ack/flush in; held exception status and counter out)
module except_fetch_unit #(
  parameter int           N      = 64,
  parameter int           NUM_BP = 4,
  parameter logic [N-1:0] MEM_LO = '0,
  parameter logic [N-1:0] MEM_HI = 64'hFFFF_FFFF,
  parameter int           CNT_W  = 16
) (
  input logic               clk,
  input logic               reset,
  except_fetch_unit_if.slave bus
);
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t           state, state_next;
  logic             bp_arm  [NUM_BP];
  logic [N-1:0]     bp_addr [NUM_BP];
  logic [3:0]       sig_q;
  logic [3:0]       cause_q;
  logic [N-1:0]     pc_q;
  logic [CNT_W-1:0] count_q;

  logic             below_lo, above_hi;
  logic             bp_match;
  logic [3:0]       raw;
  logic [3:0]       cause_next;
  logic             capture, release_held;

  // Range bounds at the extremes of the address space can never be violated;
  // elaborate those comparisons away instead of comparing against a constant.
  if (MEM_LO == '0) begin : g_lo_open
    assign below_lo = 1'b0;
  end else begin : g_lo_cmp
    assign below_lo = bus.PC < MEM_LO;
  end

  if (MEM_HI == '1) begin : g_hi_open
    assign above_hi = 1'b0;
  end else begin : g_hi_cmp
    assign above_hi = bus.PC > MEM_HI;
  end

  // Breakpoint compare uses the registered entries, so a write landing this
  // cycle is only seen from the next cycle on.
  always_comb begin
    bp_match = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_arm[i] && (bp_addr[i] == bus.PC)) bp_match = 1'b1;
    end
  end

  always_comb begin
    raw = 4'b0000;
    if (bus.fetchValid) begin
      raw[3] = bp_match;
      raw[2] = bus.pageFault;
      raw[1] = below_lo | above_hi;
      raw[0] = bus.iAlign ? bus.PC[0] : (|bus.PC[1:0]);
    end
  end

  // Priority encoder: breakpoint > page fault > access fault > misalign.
  always_comb begin
    cause_next = 4'd0;
    if (raw[3])      cause_next = 4'd3;
    else if (raw[2]) cause_next = 4'd12;
    else if (raw[1]) cause_next = 4'd1;
    else             cause_next = 4'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // A flush in the same cycle as a faulting fetch suppresses the capture;
  // while an exception is held, new fetches are ignored entirely.
  always_comb begin
    state_next   = state;
    capture      = 1'b0;
    release_held = 1'b0;
    case (state)
      IDLE: begin
        if ((|raw) && !bus.flush) begin
          state_next = PENDING;
          capture    = 1'b1;
        end
      end
      PENDING: begin
        if (bus.exceptAck || bus.flush) begin
          state_next   = IDLE;
          release_held = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding register; the PC is intentionally kept after release so trap
  // logic can still read it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q   <= 4'b0000;
      cause_q <= 4'd0;
      pc_q    <= '0;
      count_q <= '0;
    end else if (capture) begin
      sig_q   <= raw;
      cause_q <= cause_next;
      pc_q    <= bus.PC;
      if (count_q != '1) count_q <= count_q + CNT_W'(1);
    end else if (release_held) begin
      sig_q   <= 4'b0000;
      cause_q <= 4'd0;
    end
  end

  // Breakpoint programming is accepted regardless of the exception state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BP; i++) begin
        bp_arm[i]  <= 1'b0;
        bp_addr[i] <= '0;
      end
    end else if (bus.bpWrEn) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (IDX_W'(i) == bus.bpWrIdx) begin
          bp_arm[i]  <= bus.bpWrArm;
          bp_addr[i] <= bus.bpWrAddr;
        end
      end
    end
  end

  assign bus.exceptValid  = (state == PENDING);
  assign bus.fetchStall   = (state == PENDING);
  assign bus.exceptSignal = sig_q;
  assign bus.exceptCause  = cause_q;
  assign bus.exceptPC     = pc_q;
  assign bus.exceptCount  = count_q;

endmodule

// File: tb/tb_except_fetch_unit.sv
// tb_except_fetch_unit
//   Directed and randomized bench for except_fetch_unit. A behavioural model
//   of the held exception, counter and breakpoint table predicts every output.
module tb_except_fetch_unit;
  localparam int          N      = 64;
  localparam int          NUM_BP = 4;
  localparam int          CNT_W  = 16;
  localparam logic [63:0] P_LO   = 64'h0;
  localparam logic [63:0] P_HI   = 64'hFFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] mem_lo = P_LO;
  logic [63:0] mem_hi = P_HI;

  except_fetch_unit_if #(.N(N), .NUM_BP(NUM_BP), .CNT_W(CNT_W)) bus ();

  except_fetch_unit #(
    .N(N), .NUM_BP(NUM_BP), .MEM_LO(P_LO), .MEM_HI(P_HI), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic             m_valid;
  logic [3:0]       m_sig;
  logic [3:0]       m_cause;
  logic [63:0]      m_pc;
  logic [CNT_W-1:0] m_count;
  logic             m_arm  [NUM_BP];
  logic [63:0]      m_addr [NUM_BP];

  task automatic resetModel();
    m_valid = 1'b0;
    m_sig   = 4'b0;
    m_cause = 4'd0;
    m_pc    = 64'h0;
    m_count = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      m_arm[i]  = 1'b0;
      m_addr[i] = 64'h0;
    end
  endtask

  task automatic checkField(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string step);
    checkField({step, " valid"}, 64'(bus.exceptValid), 64'(m_valid));
    checkField({step, " stall"}, 64'(bus.fetchStall), 64'(m_valid));
    checkField({step, " signal"}, 64'(bus.exceptSignal), 64'(m_sig));
    checkField({step, " cause"}, 64'(bus.exceptCause), 64'(m_cause));
    checkField({step, " pc"}, bus.exceptPC, m_pc);
    checkField({step, " count"}, 64'(bus.exceptCount), 64'(m_count));
  endtask

  task automatic applyStimulus(input logic fv, input logic [63:0] pc, input logic ia,
                               input logic pf, input logic ack, input logic fl);
    bus.fetchValid = fv;
    bus.PC         = pc;
    bus.iAlign     = ia;
    bus.pageFault  = pf;
    bus.exceptAck  = ack;
    bus.flush      = fl;
    bus.bpWrEn     = 1'b0;
    bus.bpWrIdx    = 2'd0;
    bus.bpWrAddr   = 64'h0;
    bus.bpWrArm    = 1'b0;
  endtask

  task automatic writeBp(input logic [1:0] idx, input logic [63:0] addr, input logic arm);
    bus.bpWrEn   = 1'b1;
    bus.bpWrIdx  = idx;
    bus.bpWrAddr = addr;
    bus.bpWrArm  = arm;
  endtask

  // Advance one clock edge: derive the exception from the current inputs and
  // model state, then compare every output 1 time unit after the edge.
  task automatic stepCycle(input string step);
    logic        fv, ia, pf, ack, fl, we, warm, hit;
    logic [63:0] pc, waddr;
    logic [1:0]  widx;
    logic [3:0]  raw, cause;
    fv = bus.fetchValid; pc = bus.PC; ia = bus.iAlign; pf = bus.pageFault;
    ack = bus.exceptAck; fl = bus.flush;
    we = bus.bpWrEn; widx = bus.bpWrIdx; waddr = bus.bpWrAddr; warm = bus.bpWrArm;
    raw = 4'b0;
    if (fv) begin
      hit = 1'b0;
      for (int i = 0; i < NUM_BP; i++) if (m_arm[i] && m_addr[i] == pc) hit = 1'b1;
      raw[3] = hit;
      raw[2] = pf;
      raw[1] = (pc < mem_lo) || (pc > mem_hi);
      raw[0] = ia ? (pc % 2 != 0) : (pc % 4 != 0);
    end
    if (raw[3])      cause = 4'd3;
    else if (raw[2]) cause = 4'd12;
    else if (raw[1]) cause = 4'd1;
    else             cause = 4'd0;
    @(posedge clk);
    #1;
    if (!m_valid) begin
      if (raw != 4'b0 && !fl) begin
        m_valid = 1'b1;
        m_sig   = raw;
        m_cause = cause;
        m_pc    = pc;
        if (m_count != {CNT_W{1'b1}}) m_count = m_count + 1'b1;
      end
    end else if (ack || fl) begin
      m_valid = 1'b0;
      m_sig   = 4'b0;
      m_cause = 4'd0;
    end
    if (we) begin
      m_arm[widx]  = warm;
      m_addr[widx] = waddr;
    end
    checkOutput(step);
  endtask

  initial begin
    logic [63:0] rpc;
    logic [63:0] rwa;
    resetModel();
    applyStimulus(0, 64'h0, 0, 0, 0, 0);
    #12;
    checkOutput("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Misaligned fetch under 4-byte alignment
    applyStimulus(1, 64'h1002, 0, 0, 0, 0);
    stepCycle("t1");
    checkField("t1 fixed signal", 64'(bus.exceptSignal), 64'h1);
    checkField("t1 fixed pc", bus.exceptPC, 64'h1002);
    applyStimulus(0, 64'h0, 0, 0, 1, 0);
    stepCycle("t1 ack");

    // Compressed alignment
    applyStimulus(1, 64'h1002, 1, 0, 0, 0);
    stepCycle("t2 legal");
    checkField("t2 fixed novalid", 64'(bus.exceptValid), 64'h0);
    applyStimulus(1, 64'h1003, 1, 0, 0, 0);
    stepCycle("t2 odd");
    checkField("t2 fixed signal", 64'(bus.exceptSignal), 64'h1);
    applyStimulus(0, 64'h0, 0, 0, 1, 0);
    stepCycle("t2 ack");

    // Breakpoint plus page fault
    applyStimulus(0, 64'h0, 0, 0, 0, 0);
    writeBp(2'd2, 64'h2000, 1);
    stepCycle("t3 arm");
    applyStimulus(1, 64'h2000, 0, 1, 0, 0);
    stepCycle("t3 hit");
    checkField("t3 fixed signal", 64'(bus.exceptSignal), 64'hC);
    checkField("t3 fixed cause", 64'(bus.exceptCause), 64'h3);
    applyStimulus(0, 64'h0, 0, 0, 1, 0);
    stepCycle("t3 ack");

    // Access fault above the fetchable range
    applyStimulus(1, P_HI + 64'd4, 0, 0, 0, 0);
    stepCycle("t4 acc");
    checkField("t4 fixed cause", 64'(bus.exceptCause), 64'h1);
    checkField("t4 fixed stall", 64'(bus.fetchStall), 64'h1);
    applyStimulus(0, 64'h0, 0, 0, 1, 0);
    stepCycle("t4 ack");
    checkField("t4 fixed stall clr", 64'(bus.fetchStall), 64'h0);

    // Flush beats a faulting fetch; held values ignore later fetches
    applyStimulus(1, 64'h1001, 0, 1, 0, 1);
    stepCycle("t5 flush");
    checkField("t5 fixed count", 64'(bus.exceptCount), 64'd4);
    applyStimulus(0, 64'h0, 0, 0, 1, 0);
    stepCycle("t5 idle ack");
    applyStimulus(1, 64'h3002, 0, 0, 0, 0);
    stepCycle("t5 cap");
    applyStimulus(1, 64'h2000, 0, 1, 0, 0);
    stepCycle("t5 held");
    checkField("t5 fixed pc", bus.exceptPC, 64'h3002);
    applyStimulus(0, 64'h0, 0, 0, 1, 1);
    stepCycle("t5 ackflush");

    // Write and compare on the same entry in one cycle sees the old entry
    applyStimulus(1, 64'h4000, 0, 0, 0, 0);
    writeBp(2'd1, 64'h4000, 1);
    stepCycle("t5 wr same");
    checkField("t5 fixed old bp", 64'(bus.exceptValid), 64'h0);
    applyStimulus(1, 64'h4000, 0, 0, 0, 0);
    stepCycle("t5 new bp");
    checkField("t5 fixed new cause", 64'(bus.exceptCause), 64'h3);

    // Reset while pending: immediate clear, breakpoints disarmed
    applyStimulus(0, 64'h0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    resetModel();
    #1;
    checkOutput("t6 reset");
    rst_n = 1'b1;
    applyStimulus(1, 64'h2000, 0, 0, 0, 0);
    stepCycle("t6 disarmed");
    applyStimulus(1, 64'h4000, 0, 0, 0, 0);
    stepCycle("t6 disarmed2");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0:       rpc = m_addr[$urandom_range(0, NUM_BP - 1)];
        1:       rpc = P_HI + 64'($urandom_range(0, 7)) - 64'd3;
        2:       rpc = {$urandom(), $urandom()};
        default: begin
          rpc = {32'h0, $urandom()};
          if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
        end
      endcase
      applyStimulus(($urandom_range(0, 9) < 7), rpc, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 4),
                    ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 19) < 3) begin
        rwa = {32'h0, $urandom()};
        rwa[1:0] = 2'b00;
        writeBp(2'($urandom_range(0, NUM_BP - 1)), rwa, 1'($urandom_range(0, 3) != 0));
      end
      stepCycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
